sumador_serie: RTL and testbench

SUMADOR_SERIE -- requirements
Module: sumador_serie

---
 rtl/sumador_pkg.sv | 19 +
 rtl/sumador_completo.sv | 15 +
 rtl/sumador_serie.sv | 117 +++++++++++
 tb/tb_sumador_serie.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared definitions for the serial add/subtract block family.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
// Purely declarative; no logic or latency of its own.
package sumador_pkg;

  localparam int SUMADOR_N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// One-bit full adder: s = a^b^ci, co = majority(a,b,ci).
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are consumed.
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial unsigned adder, LSB first, one full adder reused over N cycles.
// Latency: start accepted at edge t -> registered done pulse after edge t+N+1.
// start is only honoured in IDLE; requests while busy are dropped, not queued.
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int N = SUMADOR_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, b_q, r_q, s_q;
  logic          c_q, cout_q, done_q;
  logic [CW-1:0] cnt_q;

  logic          load_op, shift_en, fin;
  logic          sum_bit, carry_bit;

  // The single full adder always works on the current LSB of the shifting operands.
  sumador_completo u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (sum_bit),
    .co (carry_bit)
  );

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: RUN exits after the counter has reached the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    load_op  = 1'b0;
    shift_en = 1'b0;
    fin      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: load_op = start;
      ST_RUN: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      ST_FIN: begin
        fin  = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish on leaving FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load_op) begin
        a_q   <= A;
        b_q   <= B;
        c_q   <= Cin;
        r_q   <= '0;
        cnt_q <= '0;
      end else if (shift_en) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        c_q <= carry_bit;
        // New sum bit enters at the top; after N shifts bit 0 sits at index 0.
        r_q <= {sum_bit, r_q[N-1:1]};
        // Saturate on the last bit so the counter never wraps inside RUN.
        if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CW'(1);
      end
      if (fin) begin
        s_q    <= r_q;
        cout_q <= c_q;
      end
    end
  end

  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Directed self-checking bench for sumador_serie with N=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every wait on done is bounded by a cycle budget.
module tb_sumador_serie;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [N-1:0] S;
  logic         Cout;

  int n_checks = 0;
  int n_fail   = 0;

  sumador_serie #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then wait for done. Returns edges from the
  // accepting edge to the done sample, and samples where busy was high.
  task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         input logic [N-1:0] s_prev, input logic cout_prev,
                         output int lat, output int busy_cnt);
    A = a; B = b; Cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      n_checks++;
      if (S !== s_prev || Cout !== cout_prev) begin
        n_fail++;
        $display("FAIL hold_during_run: S=%0d Cout=%0b required S=%0d Cout=%0b", S, Cout, s_prev, cout_prev);
      end
      step();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b S=%0d Cout=%b required 0 0 0 0", busy, done, S, Cout);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_add(4'd15, 4'd11, 1'b0, 4'd0, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL latency: got %0d required 5", lat); end
    n_checks++;
    if (bc !== 5) begin n_fail++; $display("FAIL busy_cycles: got %0d required 5", bc); end
    n_checks++;
    if (S !== 4'd10 || Cout !== 1'b1) begin
      n_fail++; $display("FAIL sum_15_11: S=%0d Cout=%b required S=10 Cout=1", S, Cout);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse: done=%b required 0", done); end
    n_checks++;
    if (S !== 4'd10 || Cout !== 1'b1) begin
      n_fail++; $display("FAIL result_hold: S=%0d Cout=%b required S=10 Cout=1", S, Cout);
    end

    run_add(4'd7, 4'd8, 1'b0, 4'd10, 1'b1, lat, bc);
    n_checks++;
    if (lat !== 5 || S !== 4'd15 || Cout !== 1'b0) begin
      n_fail++; $display("FAIL sum_7_8: lat=%0d S=%0d Cout=%b required 5 15 0", lat, S, Cout);
    end
    step();
    run_add(4'd0, 4'd0, 1'b0, 4'd15, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5 || S !== 4'd0 || Cout !== 1'b0) begin
      n_fail++; $display("FAIL sum_0_0: lat=%0d S=%0d Cout=%b required 5 0 0", lat, S, Cout);
    end
    step();
    run_add(4'd15, 4'd0, 1'b1, 4'd0, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5 || S !== 4'd0 || Cout !== 1'b1) begin
      n_fail++; $display("FAIL carry_ripple: lat=%0d S=%0d Cout=%b required 5 0 1", lat, S, Cout);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    A = 4'd3; B = 4'd4; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    A = 4'd9; B = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dones++;
        n_checks++;
        if (S !== 4'd7 || Cout !== 1'b0) begin
          n_fail++; $display("FAIL ignore_start_sum: S=%0d Cout=%b required S=7 Cout=0", S, Cout);
        end
      end
      step();
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignore_start_dones: got %0d required 1", dones); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    int lat, bc;
    A = 4'd15; B = 4'd15; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b S=%0d Cout=%b required 0 0 0 0", busy, done, S, Cout);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      step();
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", dones); end
    run_add(4'd1, 4'd1, 1'b0, 4'd0, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5 || S !== 4'd2 || Cout !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_sum: lat=%0d S=%0d Cout=%b required 5 2 0", lat, S, Cout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int k;
    logic [N:0] expv;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          A = N'(a); B = N'(b); Cin = c[0];
          expv = (N+1)'(a + b + c);
          k = 0;
          do begin
            step();
            k++;
          end while (!done && k < 20);
          n_checks++;
          if (k !== 6) begin
            n_fail++; $display("FAIL sweep_period a=%0d b=%0d c=%0d: got %0d required 6", a, b, c, k);
          end
          n_checks++;
          if ({Cout, S} !== expv) begin
            n_fail++;
            $display("FAIL sweep_sum a=%0d b=%0d c=%0d: Cout,S=%0d required %0d", a, b, c, {Cout, S}, expv);
          end
        end
      end
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
